// File: rtl/led_decoder_multiplexer_pkg.sv
// Shared cell descriptor types for the LED controller.
// Also holds the display geometry constants and the digit-count clamp.
package led_decoder_multiplexer_pkg;

  localparam int SEGMENTS   = 7;
  localparam int MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    CELL_TYPE_NONE    = 2'd0,
    CELL_TYPE_LED     = 2'd1,
    CELL_TYPE_DISPLAY = 2'd2
  } cell_type_t;

  typedef struct packed {
    logic [2:0]  digit_count;
    logic [15:0] value;
  } display_data_t;

  typedef struct packed {
    logic [17:0] reserved;
    logic        value;
  } led_data_t;

  typedef union packed {
    led_data_t     led;
    display_data_t display;
  } cell_data_t;

  typedef struct packed {
    cell_type_t cell_type;
    cell_data_t data;
  } cell_t;

  function automatic logic [2:0] eff_digits(logic [2:0] dc);
    return (dc > 3'(MAX_DIGITS)) ? 3'(MAX_DIGITS) : dc;
  endfunction

endpackage

// File: rtl/led_decoder_multiplexer_if.sv
// Step/data/busy/bit bundle between the cell sequencer
// and the LED bit serializer.
interface led_decoder_multiplexer_if;
  import led_decoder_multiplexer_pkg::*;

  logic  decode_next_led;
  cell_t data;
  logic  busy;
  logic  led_out;

  modport master (
    output decode_next_led,
    output data,
    input  busy,
    input  led_out
  );

  modport slave (
    input  decode_next_led,
    input  data,
    output busy,
    output led_out
  );
endinterface

// File: rtl/led_decoder_multiplexer_hex_to_7seg.sv
// Hex nibble to active-high 7-segment pattern.
// Output bit 6 is segment a, bit 0 is segment g.
module led_decoder_multiplexer_hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);
  // Standard 0-9, A, b, C, d, E, F glyphs
  always_comb begin
    segs = 7'b0000000;
    unique case (nibble)
      4'h0: segs = 7'b1111110;
      4'h1: segs = 7'b0110000;
      4'h2: segs = 7'b1101101;
      4'h3: segs = 7'b1111001;
      4'h4: segs = 7'b0110011;
      4'h5: segs = 7'b1011011;
      4'h6: segs = 7'b1011111;
      4'h7: segs = 7'b1110000;
      4'h8: segs = 7'b1111111;
      4'h9: segs = 7'b1111011;
      4'hA: segs = 7'b1110111;
      4'hB: segs = 7'b0011111;
      4'hC: segs = 7'b1001110;
      4'hD: segs = 7'b0111101;
      4'hE: segs = 7'b1001111;
      4'hF: segs = 7'b1000111;
      default: segs = 7'b0000000;
    endcase
  end
endmodule

// File: rtl/led_decoder_multiplexer.sv
// Serializes one cell descriptor into single LED bits,
// one bit per step; display digits go LSB nibble first, a..g.
module led_decoder_multiplexer
  import led_decoder_multiplexer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  led_decoder_multiplexer_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_DISPLAY_ACTIVE
  } state_t;

  state_t      state_q, state_d;
  logic        led_q, led_d;
  logic        busy_q, busy_d;
  logic [2:0]  seg_q, seg_d;
  logic [1:0]  dig_q, dig_d;
  logic [2:0]  ndig_q, ndig_d;
  logic [15:0] value_q, value_d;

  logic [3:0] nib;
  logic [6:0] segs;
  logic [2:0] in_n;
  logic       last_dig;

  // The first digit comes straight from the input; later ones from the latch
  always_comb begin
    nib = (state_q == ST_IDLE) ? bus.data.data.display.value[3:0]
                               : value_q[{dig_q, 2'b00} +: 4];
  end

  led_decoder_multiplexer_hex_to_7seg u_hex (
    .nibble (nib),
    .segs   (segs)
  );

  assign in_n     = eff_digits(bus.data.data.display.digit_count);
  assign last_dig = ({1'b0, dig_q} == ndig_q - 3'd1);

  // Next-state: start a cell from IDLE, or emit the next segment
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    busy_d  = busy_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    ndig_d  = ndig_q;
    value_d = value_q;
    if (bus.decode_next_led) begin
      if (state_q == ST_IDLE) begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        seg_d  = 3'd0;
        dig_d  = 2'd0;
        unique case (1'b1)
          (bus.data.cell_type == CELL_TYPE_LED): begin
            led_d = bus.data.data.led.value;
          end
          (bus.data.cell_type == CELL_TYPE_DISPLAY
           && in_n != 3'd0): begin
            led_d   = segs[6];
            seg_d   = 3'd1;
            ndig_d  = in_n;
            value_d = bus.data.data.display.value;
            busy_d  = 1'b1;
            state_d = ST_DISPLAY_ACTIVE;
          end
          default: ;
        endcase
      end else begin
        led_d = segs[3'd6 - seg_q];
        if (seg_q == 3'(SEGMENTS - 1)) begin
          seg_d = 3'd0;
          if (last_dig) begin
            dig_d   = 2'd0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            dig_d = dig_q + 2'd1;
          end
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= 3'd0;
      dig_q   <= 2'd0;
      ndig_q  <= 3'd0;
      value_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      ndig_q  <= ndig_d;
      value_q <= value_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.led_out = led_q;

endmodule

// File: tb/tb_led_decoder_multiplexer.sv
// Directed bench for the LED bit serializer.
// Expected segment patterns are hand-entered constants.
module tb_led_decoder_multiplexer;
  import led_decoder_multiplexer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  led_decoder_multiplexer_if bus ();

  led_decoder_multiplexer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h7: g = 7'b1110000;
      4'hA: g = 7'b1110111;
      default: g = 7'bxxxxxxx;
    endcase
    return g;
  endfunction

  function automatic cell_t mk_disp(input logic [2:0] dc,
                                    input logic [15:0] v);
    cell_t c;
    c = {CELL_TYPE_DISPLAY, dc, v};
    return c;
  endfunction

  function automatic cell_t mk_led(input logic v);
    cell_t c;
    c = {CELL_TYPE_LED, 18'd0, v};
    return c;
  endfunction

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk) bus.decode_next_led = 1'b1;
    @(negedge clk) bus.decode_next_led = 1'b0;
  endtask

  logic [6:0]  g;
  logic [15:0] v;

  initial begin
    bus.decode_next_led = 1'b0;
    bus.data = '0;

    // reset two cycles
    repeat (2) @(negedge clk);
    chk("rst_led", bus.led_out, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_led", bus.led_out, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);

    // LED cells
    bus.data = mk_led(1'b1);
    step();
    chk("led1", bus.led_out, 1'b1);
    chk("led1_busy", bus.busy, 1'b0);
    bus.data = mk_led(1'b0);
    step();
    chk("led0", bus.led_out, 1'b0);

    // one digit of A5A5 -> digit 5
    bus.data = mk_disp(3'd1, 16'hA5A5);
    g = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("d1_bit%0d", i), bus.led_out, g[6-i]);
      chk($sformatf("d1_busy%0d", i), bus.busy, i < 6);
    end

    // two digits, data scrambled after the first digit
    bus.data = mk_disp(3'd2, 16'hA5A5);
    for (int i = 0; i < 14; i++) begin
      g = (i < 7) ? 7'b1011011 : 7'b1110111;
      step();
      if (i == 6) bus.data = mk_disp(3'd4, 16'h1111);
      chk($sformatf("d2_bit%0d", i), bus.led_out, g[6-(i%7)]);
      chk($sformatf("d2_busy%0d", i), bus.busy, i < 13);
    end

    // digit_count 0: empty cell, led_out falls from 1
    bus.data = mk_disp(3'd0, 16'hFFFF);
    step();
    chk("dc0_led", bus.led_out, 1'b0);
    chk("dc0_busy", bus.busy, 1'b0);

    // digit_count 7 clamps to 4 digits
    v = 16'h1234;
    bus.data = mk_disp(3'd7, v);
    for (int i = 0; i < 28; i++) begin
      g = glyph(v[(i/7)*4 +: 4]);
      step();
      chk($sformatf("dc7_bit%0d", i), bus.led_out, g[6-(i%7)]);
      chk($sformatf("dc7_busy%0d", i), bus.busy, i < 27);
    end

    // back-to-back burst: one digit in 7 consecutive cycles
    bus.data = mk_disp(3'd1, 16'h0002);
    g = glyph(4'h2);
    @(negedge clk) bus.decode_next_led = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 6) bus.decode_next_led = 1'b0;
      chk($sformatf("burst_bit%0d", i), bus.led_out, g[6-i]);
      chk($sformatf("burst_busy%0d", i), bus.busy, i < 6);
    end

    // reset after step 3, with a step in the same cycle
    bus.data = mk_disp(3'd2, 16'h0005);
    repeat (3) step();
    chk("mid_busy_pre", bus.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.decode_next_led = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.decode_next_led = 1'b0;
    chk("mid_rst_led", bus.led_out, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    bus.data = mk_disp(3'd1, 16'h0004);
    step();
    chk("fresh_a", bus.led_out, 1'b0);
    chk("fresh_busy", bus.busy, 1'b1);
    step();
    chk("fresh_b", bus.led_out, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
